// File: rtl/io_timebase_pkg.sv
// Shared constants and width helpers for the I/O timebase and clear sequencer.
package io_timebase_pkg;

    localparam logic [1:0]  OC_XTAL1        = 2'b11;
    localparam logic [1:0]  OC_XTAL2        = 2'b10;

    localparam int unsigned DEF_POC_CYCLES  = 568;
    localparam int unsigned DEF_CLR_STRETCH = 4;
    localparam int unsigned DEF_DIV0_INIT   = 7;
    localparam int unsigned DEF_DIVN_INIT   = 15;

    localparam int unsigned POC_CNT_MIN_W   = 11;
    localparam int unsigned DIV_CH_W        = 3;

    // Bits needed to index n entries (0..n-1), never less than one.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Power-on counter width: holds the terminal count, at least 11 bits.
    function automatic int unsigned poc_cnt_w(input int unsigned cycles);
        int unsigned w;
        w = POC_CNT_MIN_W;
        while ((64'd1 << w) <= 64'(cycles)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/io_tb_divider.sv
// One programmable divider channel: counter, active/pending divisor and cascade bit.
module io_tb_divider
    import io_timebase_pkg::*;
#(
    parameter int unsigned DIV_W     = 8,
    parameter int unsigned DIV_INIT  = 7,
    parameter logic        CASC_INIT = 1'b0
) (
    input  logic             sysclk,
    input  logic             sys_rst,
    input  logic             clr,
    input  logic             src_tick,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
    input  logic             wr_casc,
    output logic             casc,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] pend_div_r;
    logic             casc_r;
    logic             pend_casc_r;
    logic             tick_r;

    logic [DIV_W-1:0] pend_div_s;
    logic             pend_casc_s;
    logic             wrap_s;

    // Pending value as seen this cycle, so a write landing on a wrap is taken at once.
    always_comb begin
        if (wr_en) begin
            pend_div_s  = wr_div;
            pend_casc_s = wr_casc;
        end else begin
            pend_div_s  = pend_div_r;
            pend_casc_s = pend_casc_r;
        end
        wrap_s = src_tick && (cnt_r == div_r);
    end

    // Counter, divisor hand-over and single-cycle wrap pulse.
    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            cnt_r       <= {DIV_W{1'b0}};
            div_r       <= DIV_W'(DIV_INIT);
            pend_div_r  <= DIV_W'(DIV_INIT);
            casc_r      <= CASC_INIT;
            pend_casc_r <= CASC_INIT;
            tick_r      <= 1'b0;
        end else begin
            pend_div_r  <= pend_div_s;
            pend_casc_r <= pend_casc_s;
            if (clr) begin
                cnt_r  <= {DIV_W{1'b0}};
                tick_r <= 1'b0;
                div_r  <= pend_div_s;
                casc_r <= pend_casc_s;
            end else if (wrap_s) begin
                cnt_r  <= {DIV_W{1'b0}};
                tick_r <= 1'b1;
                div_r  <= pend_div_s;
                casc_r <= pend_casc_s;
            end else if (src_tick) begin
                cnt_r  <= cnt_r + DIV_W'(1);
                tick_r <= 1'b0;
            end else begin
                tick_r <= 1'b0;
            end
        end
    end

    assign casc = casc_r;
    assign tick = tick_r;

endmodule

// File: rtl/io_timebase.sv
// I/O timebase: power-on clear, oscillator-divider clear, stretched master clear,
// oscillator select and NCH runtime-programmable, optionally cascaded dividers.
module io_timebase
    import io_timebase_pkg::*;
#(
    parameter int unsigned POC_CYCLES  = DEF_POC_CYCLES,
    parameter int unsigned CLR_STRETCH = DEF_CLR_STRETCH,
    parameter int unsigned NCH         = 2,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DIV0_INIT   = DEF_DIV0_INIT,
    parameter int unsigned DIVN_INIT   = DEF_DIVN_INIT
) (
    input  logic             sysclk,
    input  logic             sys_rst,
    input  logic             xtal1_tick,
    input  logic             xtal2_tick,
    input  logic [1:0]       oc_1_0,
    input  logic             osccl_n,
    input  logic             swmcl_n,
    input  logic             opclcs,
    input  logic             div_we,
    input  logic [2:0]       div_ch,
    input  logic [DIV_W-1:0] div_wdata,
    input  logic             div_wcasc,
    output logic             osc_tick,
    output logic             poc,
    output logic             closc,
    output logic             pwcl,
    output logic [NCH-1:0]   tick_out
);

    localparam int unsigned POC_W = poc_cnt_w(POC_CYCLES);
    localparam int unsigned STR_W = ch_idx_w(CLR_STRETCH + 1);

    logic [POC_W-1:0] poc_cnt_r;
    logic [POC_W-1:0] poc_cnt_nxt_s;
    logic             poc_r;
    logic             closc_r;
    logic             pwcl_r;
    logic             pwcl_src_s;
    logic [STR_W-1:0] str_cnt_r;
    logic             osc_tick_r;
    logic             osc_sel_s;

    logic [NCH-1:0]   tick_s;
    logic [NCH-1:0]   prev_tick_s;
    logic [NCH-1:0]   casc_s;
    logic [NCH-1:0]   src_s;
    logic [NCH-1:0]   wr_s;

    // Power-on counter saturates at the terminal count.
    always_comb begin
        if (poc_cnt_r != POC_W'(POC_CYCLES)) begin
            poc_cnt_nxt_s = poc_cnt_r + POC_W'(1);
        end else begin
            poc_cnt_nxt_s = poc_cnt_r;
        end
        pwcl_src_s = poc_r | ~swmcl_n | opclcs;
    end

    // Power-on clear sequence.
    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            poc_cnt_r <= {POC_W{1'b0}};
            poc_r     <= 1'b1;
        end else begin
            poc_cnt_r <= poc_cnt_nxt_s;
            poc_r     <= (poc_cnt_nxt_s != POC_W'(POC_CYCLES));
        end
    end

    // Divider clear and stretched master clear; each new source restarts the stretch.
    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            closc_r   <= 1'b1;
            pwcl_r    <= 1'b1;
            str_cnt_r <= STR_W'(CLR_STRETCH);
        end else begin
            closc_r <= poc_r | ~osccl_n;
            if (pwcl_src_s) begin
                pwcl_r    <= 1'b1;
                str_cnt_r <= STR_W'(CLR_STRETCH);
            end else if (str_cnt_r != {STR_W{1'b0}}) begin
                pwcl_r    <= 1'b1;
                str_cnt_r <= str_cnt_r - STR_W'(1);
            end else begin
                pwcl_r    <= 1'b0;
            end
        end
    end

    // Oscillator source select; stuck-level encodings give no ticks.
    always_comb begin
        case (oc_1_0)
            OC_XTAL1: osc_sel_s = xtal1_tick;
            OC_XTAL2: osc_sel_s = xtal2_tick;
            default:  osc_sel_s = 1'b0;
        endcase
    end

    // Registered oscillator tick.
    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            osc_tick_r <= 1'b0;
        end else begin
            osc_tick_r <= osc_sel_s;
        end
    end

    // Channel source mux: bit i of prev_tick_s is channel i-1's pulse.
    always_comb begin
        prev_tick_s = tick_s << 1;
        src_s       = {NCH{1'b0}};
        for (int i = 0; i < int'(NCH); i++) begin
            if ((i != 0) && casc_s[i]) begin
                src_s[i] = prev_tick_s[i];
            end else begin
                src_s[i] = osc_tick_r;
            end
        end
    end

    for (genvar i = 0; i < int'(NCH); i++) begin : g_ch
        assign wr_s[i] = div_we && (div_ch == DIV_CH_W'(i));

        io_tb_divider #(
            .DIV_W     (DIV_W),
            .DIV_INIT  ((i == 0) ? DIV0_INIT : DIVN_INIT),
            .CASC_INIT ((i == 0) ? 1'b0 : 1'b1)
        ) u_div (
            .sysclk   (sysclk),
            .sys_rst  (sys_rst),
            .clr      (closc_r),
            .src_tick (src_s[i]),
            .wr_en    (wr_s[i]),
            .wr_div   (div_wdata),
            .wr_casc  (div_wcasc),
            .casc     (casc_s[i]),
            .tick     (tick_s[i])
        );
    end

    assign osc_tick = osc_tick_r;
    assign poc      = poc_r;
    assign closc    = closc_r;
    assign pwcl     = pwcl_r;
    assign tick_out = tick_s;

endmodule

// File: tb/tb_io_timebase.sv
// Scoreboard bench for io_timebase: an event-level reference model predicts levels and wrap pulses.
module tb_io_timebase;

    localparam int NCH   = 2;
    localparam int DIV_W = 8;
    localparam int POC   = 568;
    localparam int STR   = 4;
    localparam int D0    = 7;
    localparam int DN    = 15;

    logic             sysclk = 1'b0;
    logic             sys_rst;
    logic             xtal1_tick;
    logic             xtal2_tick;
    logic [1:0]       oc_1_0;
    logic             osccl_n;
    logic             swmcl_n;
    logic             opclcs;
    logic             div_we;
    logic [2:0]       div_ch;
    logic [DIV_W-1:0] div_wdata;
    logic             div_wcasc;
    logic             osc_tick;
    logic             poc;
    logic             closc;
    logic             pwcl;
    logic [NCH-1:0]   tick_out;

    always #5 sysclk = ~sysclk;

    io_timebase #(
        .POC_CYCLES(POC), .CLR_STRETCH(STR), .NCH(NCH),
        .DIV_W(DIV_W), .DIV0_INIT(D0), .DIVN_INIT(DN)
    ) dut (
        .sysclk(sysclk), .sys_rst(sys_rst),
        .xtal1_tick(xtal1_tick), .xtal2_tick(xtal2_tick), .oc_1_0(oc_1_0),
        .osccl_n(osccl_n), .swmcl_n(swmcl_n), .opclcs(opclcs),
        .div_we(div_we), .div_ch(div_ch), .div_wdata(div_wdata), .div_wcasc(div_wcasc),
        .osc_tick(osc_tick), .poc(poc), .closc(closc), .pwcl(pwcl), .tick_out(tick_out)
    );

    typedef struct packed {
        logic poc;
        logic closc;
        logic pwcl;
        logic osc;
    } lvl_t;

    typedef struct packed {
        int             edge_n;
        logic [NCH-1:0] vec;
    } tk_t;

    lvl_t lvl_q[$];
    tk_t  tk_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model state: ticks counted since the last wrap, period = divisor + 1.
    int             edge_n = 0;
    int             since_rst;
    int             last_src;
    logic           m_poc, m_closc, m_pwcl, m_osc;
    int             m_k[NCH];
    int             m_d[NCH];
    int             m_pd[NCH];
    logic           m_c[NCH];
    logic           m_pc[NCH];
    logic [NCH-1:0] m_tick;
    int             xph = 0;

    task automatic step();
        logic           poc_p, closc_p, osc_p, src;
        logic [NCH-1:0] tick_n;
        logic [NCH:0]   chain;
        lvl_t           l;
        tk_t            t;
        edge_n++;
        poc_p   = m_poc;
        closc_p = m_closc;
        osc_p   = m_osc;
        chain   = {m_tick, m_osc};
        tick_n  = '0;
        if (sys_rst) begin
            since_rst = 0;
            last_src  = edge_n;
            m_poc = 1'b1; m_closc = 1'b1; m_pwcl = 1'b1; m_osc = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_k[i]  = 0;
                m_d[i]  = (i == 0) ? D0 : DN;
                m_pd[i] = m_d[i];
                m_c[i]  = (i != 0);
                m_pc[i] = m_c[i];
            end
        end else begin
            since_rst++;
            m_poc   = (since_rst < POC);
            m_closc = poc_p | ~osccl_n;
            if (poc_p | ~swmcl_n | opclcs) last_src = edge_n;
            m_pwcl  = ((edge_n - last_src) <= STR);
            case (oc_1_0)
                2'b11:   m_osc = xtal1_tick;
                2'b10:   m_osc = xtal2_tick;
                default: m_osc = 1'b0;
            endcase
            for (int i = 0; i < NCH; i++) begin
                if (div_we && (int'(div_ch) == i)) begin
                    m_pd[i] = int'(div_wdata);
                    m_pc[i] = div_wcasc;
                end
                if (closc_p) begin
                    m_k[i] = 0;
                    m_d[i] = m_pd[i];
                    m_c[i] = m_pc[i];
                end else begin
                    src = (i > 0 && m_c[i]) ? chain[i] : osc_p;
                    if (src) begin
                        m_k[i]++;
                        if (m_k[i] == m_d[i] + 1) begin
                            tick_n[i] = 1'b1;
                            m_k[i]    = 0;
                            m_d[i]    = m_pd[i];
                            m_c[i]    = m_pc[i];
                        end
                    end
                end
            end
        end
        m_tick = tick_n;
        l = '{poc: m_poc, closc: m_closc, pwcl: m_pwcl, osc: m_osc};
        lvl_q.push_back(l);
        if (tick_n != '0) begin
            t = '{edge_n: edge_n, vec: tick_n};
            tk_q.push_back(t);
        end
        @(posedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic cyc3();
        xtal1_tick = (xph % 3 == 0);
        xtal2_tick = 1'b0;
        xph++;
        step();
    endtask

    task automatic run3(input int n);
        for (int j = 0; j < n; j++) cyc3();
    endtask

    task automatic wr(input int ch, input int d, input logic c);
        div_we    = 1'b1;
        div_ch    = 3'(ch);
        div_wdata = DIV_W'(d);
        div_wcasc = c;
        cyc3();
        div_we    = 1'b0;
    endtask

    // Monitor: compares levels every cycle and each wrap pulse against the queued prediction.
    int mon_edge = 0;
    always @(posedge sysclk) begin : mon
        lvl_t l;
        tk_t  t;
        #1;
        mon_edge++;
        compared++;
        if (lvl_q.size() == 0) begin
            mismatched++;
            $display("FAIL lvl_queue edge=%0d got no prediction, required one", mon_edge);
        end else begin
            l = lvl_q.pop_front();
            if ({poc, closc, pwcl, osc_tick} !== l) begin
                mismatched++;
                $display("FAIL levels edge=%0d poc/closc/pwcl/osc got %b%b%b%b required %b%b%b%b",
                         mon_edge, poc, closc, pwcl, osc_tick, l.poc, l.closc, l.pwcl, l.osc);
            end
        end
        if (tick_out !== '0) begin
            compared++;
            if (tk_q.size() == 0) begin
                mismatched++;
                $display("FAIL tick_unexpected edge=%0d got %b required none", mon_edge, tick_out);
            end else begin
                t = tk_q.pop_front();
                if (t.edge_n != mon_edge || t.vec !== tick_out) begin
                    mismatched++;
                    $display("FAIL tick edge=%0d vec=%b required edge=%0d vec=%b",
                             mon_edge, tick_out, t.edge_n, t.vec);
                end
            end
        end
    end

    initial begin
        tk_t t;
        sys_rst = 1'b1; xtal1_tick = 1'b0; xtal2_tick = 1'b0; oc_1_0 = 2'b11;
        osccl_n = 1'b1; swmcl_n = 1'b1; opclcs = 1'b0;
        div_we = 1'b0; div_ch = 3'd0; div_wdata = '0; div_wcasc = 1'b0;
        repeat (3) step();
        sys_rst = 1'b0;
        run3(600);
        run3(420);
        // Mid-count divisor change, then a write landing exactly on a wrap.
        run3(15);
        wr(0, 3, 1'b0);
        run3(100);
        for (int g = 0; g < 200 && !(m_k[0] == m_d[0] && m_osc && !m_closc); g++) cyc3();
        wr(0, 1, 1'b0);
        run3(60);
        // Master clear pulses, the second one inside the stretch.
        swmcl_n = 1'b0; cyc3(); swmcl_n = 1'b1;
        run3(2);
        swmcl_n = 1'b0; cyc3(); swmcl_n = 1'b1;
        run3(12);
        opclcs = 1'b1; cyc3(); cyc3(); opclcs = 1'b0;
        run3(10);
        oc_1_0 = 2'b01; run3(60);
        oc_1_0 = 2'b00; run3(20);
        oc_1_0 = 2'b11; run3(40);
        // Divider clear mid-count with a pending write.
        osccl_n = 1'b0; cyc3();
        wr(1, 2, 1'b1);
        run3(6);
        osccl_n = 1'b1;
        run3(200);
        for (int j = 0; j < 2500; j++) begin
            xtal1_tick = 1'($urandom_range(0, 1));
            xtal2_tick = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) oc_1_0 = 2'($urandom_range(0, 3));
            div_we    = ($urandom_range(0, 39) == 0);
            div_ch    = 3'($urandom_range(0, 7));
            div_wdata = DIV_W'($urandom_range(0, 5));
            div_wcasc = 1'($urandom_range(0, 1));
            swmcl_n   = ($urandom_range(0, 99) != 0);
            opclcs    = ($urandom_range(0, 149) == 0);
            osccl_n   = ($urandom_range(0, 199) != 0);
            step();
        end
        div_we = 1'b0; swmcl_n = 1'b1; opclcs = 1'b0; osccl_n = 1'b1; oc_1_0 = 2'b11;
        run3(20);
        // Reset mid-operation, then an out-of-range channel write.
        sys_rst = 1'b1;
        wr(2, 0, 1'b0);
        cyc3();
        sys_rst = 1'b0;
        run3(600);
        wr(2, 0, 1'b0);
        run3(420);
        while (tk_q.size() > 0) begin
            t = tk_q.pop_front();
            compared++;
            mismatched++;
            $display("FAIL tick_missing got nothing required edge=%0d vec=%b", t.edge_n, t.vec);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
